mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameters: XLEN, default 32, operand width; TAG_W, default 4, request tag width.
REQ-002 SHALL have clk, input, 1, the single clock.
REQ-003 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have req_valid, input, 1, request offered.
REQ-005 SHALL have req_ready, output, 1, request accepted when high with req_valid.
REQ-006 SHALL have req_op, input, 3 (mul_ops), operation select.
REQ-007 SHALL have req_a, input, XLEN, multiplicand rs1.
REQ-008 SHALL have req_b, input, XLEN, multiplier rs2.
REQ-009 SHALL have req_tag, input, TAG_W, opaque tag returned with the result.
REQ-010 SHALL have kill, input, 1, abort any in-flight or pending operation.
REQ-011 SHALL have resp_valid, output, 1, result available.
REQ-012 SHALL have resp_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have resp_data, output, XLEN, selected product half.
REQ-014 SHALL have resp_tag, output, TAG_W, tag of the accepted request.
REQ-015 SHALL have busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, CALC, FIX, DONE.
REQ-017 SHALL drive req_ready = (state==IDLE) && !kill.
REQ-018 On an accept edge: capture op and tag; capture |a| and |b|, where a is signed for mul_op_h and mul_op_hsu and b is signed for mul_op_h only; record neg = sign(a) XOR sign(b) over signed operands; clear the 2*XLEN accumulator and the counter; go to CALC.
REQ-019 CALC SHALL perform one radix-2 shift-add step per cycle for exactly XLEN cycles, then go to FIX.
REQ-020 FIX SHALL two's-complement negate the 2*XLEN product when neg=1, select bits [XLEN-1:0] for mul_op and [2*XLEN-1:XLEN] otherwise, register the result into resp_data and resp_tag, and go to DONE.
REQ-021 Latency: resp_valid SHALL rise exactly XLEN+1 clock edges after the accepting edge.
REQ-022 DONE SHALL hold resp_valid, resp_data and resp_tag stable until resp_ready=1; that edge SHALL return the FSM to IDLE and clear resp_valid.
REQ-023 SHALL NOT accept a request in CALC, FIX or DONE; no bypass. Minimum issue interval is XLEN+3 cycles.
REQ-024 SHALL treat a req_op with bit 2 set as mul_op (low half, unsigned operand handling).
REQ-025 kill=1 in any state SHALL return the FSM to IDLE on the next edge, clear resp_valid, and produce no response for the aborted operation.
REQ-026 A kill in the same cycle as a DONE handshake SHALL complete the handshake, since the data was already consumed, and the FSM SHALL then go to IDLE.
REQ-027 kill together with req_valid in IDLE SHALL NOT accept the request.
REQ-028 Operands of 0 and the most negative value SHALL take the full XLEN cycles with no early exit.

Reset
REQ-029 While rst_n=0: state=IDLE, resp_valid=0, resp_data=0, resp_tag=0, busy=0, counter=0, accumulator=0.
REQ-030 Reset asserted mid-CALC or in DONE SHALL discard the operation; no response is issued after release.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 mul_ops SHALL be taken from func_types; the state enum mul_seq_state_e SHALL be added to func_types.
REQ-033 The shift-add accumulator and counter SHALL be one sub-module, mul_seq_dp, controlled by load, step and fix strobes from the FSM.
REQ-034 The counter SHALL be $clog2(XLEN)+1 bits wide; the accumulator SHALL be 2*XLEN bits wide.

Verification
REQ-035 mul_op, a=0x80000000, b=0xFFFFFFFF -> resp_data=0x80000000, resp_valid at accept+33 edges.
REQ-036 mul_op_h, a=b=0x80000000 -> 0x40000000; mul_op_hu with the same operands -> 0x40000000.
REQ-037 mul_op_hsu, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; mul_op_hu with the same operands -> 0xFFFFFFFE.
REQ-038 resp_ready held low 10 cycles in DONE -> resp_valid, resp_data and resp_tag stable; req_ready=0 throughout; IDLE the cycle after the handshake.
REQ-039 kill at CALC cycle 5, tag=3 -> no response for tag 3; a new request with tag=4 and a=7, b=6 -> resp_data=42, resp_tag=4.
REQ-040 rst_n pulsed low mid-CALC -> all outputs at reset values immediately; resp_valid stays 0 until a new request completes.

Source files
------------

// File: rtl/func_types.sv
// Shared operation and state types for the sequential multiplier.
package func_types;

    typedef enum logic [2:0] {
        mul_op     = 3'b000,
        mul_op_h   = 3'b001,
        mul_op_hsu = 3'b010,
        mul_op_hu  = 3'b011
    } mul_ops;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_seq_state_e;

    // Any encoding with bit 2 set falls back to the plain low-half multiply.
    function automatic mul_ops mul_op_decode(input logic [2:0] raw);
        mul_ops op;
        case (raw)
            3'b001:  op = mul_op_h;
            3'b010:  op = mul_op_hsu;
            3'b011:  op = mul_op_hu;
            default: op = mul_op;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Radix-2 shift-add datapath: magnitude capture, XLEN accumulate steps, sign fix.
module mul_seq_dp #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                fix,
    input  logic                a_signed,
    input  logic                b_signed,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                last,
    output logic [2*XLEN-1:0]   product
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic              neg;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN:0]     sum;

    assign a_neg = a_signed & a[XLEN-1];
    assign b_neg = b_signed & b[XLEN-1];

    // Upper half plus the partial product; the carry lands in the MSB after the shift.
    assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mplier[0] ? mcand : {XLEN{1'b0}})};

    assign product = neg ? (~acc + 1'b1) : acc;
    assign last    = (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a_neg ? (~a + 1'b1) : a;
            mplier <= b_neg ? (~b + 1'b1) : b;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= {sum, acc[XLEN-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end else if (fix) begin
            acc    <= product;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier controller: accept, XLEN shift-add steps, sign fix, hold until consumed.
module mul_seq_ctrl
    import func_types::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    mul_seq_state_e    state;
    mul_seq_state_e    state_next;
    mul_ops            op_in;
    mul_ops            op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              load;
    logic              step;
    logic              fix;
    logic              last;
    logic              a_signed;
    logic              b_signed;
    logic [2*XLEN-1:0] product;

    assign op_in    = mul_op_decode(req_op);
    assign a_signed = (op_in == mul_op_h) || (op_in == mul_op_hsu);
    assign b_signed = (op_in == mul_op_h);

    assign req_ready  = (state == IDLE) && !kill;
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

    mul_seq_dp #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .a        (req_a),
        .b        (req_b),
        .last     (last),
        .product  (product)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) state_next = FIX;
            end
            FIX: begin
                fix        = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over every transition; a simultaneous DONE handshake also lands in IDLE.
        if (kill) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= mul_op;
            tag_q     <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                op_q  <= op_in;
                tag_q <= req_tag;
            end
            if (fix) begin
                resp_data <= (op_q == mul_op) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                resp_tag  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized and directed bench for mul_seq_ctrl against a cycle-level reference model.
module tb_mul_seq_ctrl;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             kill;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    mul_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Full-precision product from the architectural definition of each op.
    function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [2:0]         o;
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [65:0] p;
        o  = op[2] ? 3'd0 : op;
        sa = {((o == 3'd1) || (o == 3'd2)) & a[31], a};
        sb = {(o == 3'd1) & b[31], b};
        p  = $signed(66'(sa)) * $signed(66'(sb));
        return (o == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    // Reference model: an operation in flight for XLEN+1 edges, then a held result.
    logic        m_inflight;
    logic        m_valid;
    int          m_cnt;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_t;
    logic [31:0] m_data;
    logic [3:0]  m_tag;
    int          m_hs = 0;
    int          d_hs = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight <= 1'b0;
            m_valid    <= 1'b0;
            m_cnt      <= 0;
        end else begin
            if (m_valid && resp_ready) m_hs <= m_hs + 1;
            if (kill) begin
                m_inflight <= 1'b0;
                m_valid    <= 1'b0;
            end else if (m_valid) begin
                if (resp_ready) m_valid <= 1'b0;
            end else if (m_inflight) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == XLEN) begin
                    m_inflight <= 1'b0;
                    m_valid    <= 1'b1;
                    m_data     <= ref_mul(m_op, m_a, m_b);
                    m_tag      <= m_t;
                end
            end else if (req_valid) begin
                m_inflight <= 1'b1;
                m_cnt      <= 0;
                m_op       <= req_op;
                m_a        <= req_a;
                m_b        <= req_b;
                m_t        <= req_tag;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_resp_data", 64'(resp_data), 64'd0);
            chk("rst_resp_tag", 64'(resp_tag), 64'd0);
        end else begin
            if (resp_valid && resp_ready) d_hs++;
            chk("req_ready", 64'(req_ready), 64'(!m_inflight && !m_valid && !kill));
            chk("busy", 64'(busy), 64'(m_inflight || m_valid));
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("resp_data", 64'(resp_data), 64'(m_data));
                chk("resp_tag", 64'(resp_tag), 64'(m_tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("send_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic direct(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
        int lat;
        send(op, a, b, tag);
        wait_resp(lat);
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_data"}, 64'(resp_data), 64'(exp));
        chk({name, "_tag"}, 64'(resp_tag), 64'(tag));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] exp;
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h7FFF_FFFF;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0;
        req_tag = '0; kill = 1'b0; resp_ready = 1'b0;

        chk("model_mul", 64'(ref_mul(3'd0, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h8000_0000);
        chk("model_hsu", 64'(ref_mul(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
        chk("model_hu",  64'(ref_mul(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);

        repeat (3) tick();
        rst_n = 1'b1;

        // First accept on the first edge after reset release.
        send(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1);
        chk("first_accept_busy", 64'(busy), 64'd1);
        wait_resp(lat);
        chk("mul_latency", 64'(lat), 64'd33);
        chk("mul_data", 64'(resp_data), 64'h8000_0000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        direct("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 4'd2, 32'h4000_0000);
        direct("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 4'd5, 32'h4000_0000);
        direct("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'hFFFF_FFFF);
        direct("mulhu2", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'hFFFF_FFFE);
        direct("op_bit2", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 32'h0000_0001);
        direct("zero",   3'd1, 32'h0000_0000, 32'h8000_0000, 4'd9, 32'h0000_0000);

        // Stall in DONE for 10 cycles.
        exp = ref_mul(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        send(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd10);
        wait_resp(lat);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(resp_valid), 64'd1);
            chk("stall_data", 64'(resp_data), 64'(exp));
            chk("stall_tag", 64'(resp_tag), 64'd10);
            chk("stall_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("after_hs_busy", 64'(busy), 64'd0);
        chk("after_hs_valid", 64'(resp_valid), 64'd0);

        // Kill at CALC cycle 5.
        send(3'd0, $urandom, $urandom, 4'd3);
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_busy", 64'(busy), 64'd0);
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        resp_ready = 1'b0;
        chk("kill_no_resp", 64'(seen), 64'd0);
        direct("after_kill", 3'd0, 32'd7, 32'd6, 4'd4, 32'd42);

        // Kill blocks an IDLE accept.
        kill = 1'b1; req_valid = 1'b1;
        tick();
        kill = 1'b0; req_valid = 1'b0;
        chk("kill_idle_busy", 64'(busy), 64'd0);

        // Reset pulsed mid-CALC.
        send(3'd3, $urandom, $urandom, 4'd11);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_data", 64'(resp_data), 64'd0);
        chk("midrst_tag", 64'(resp_tag), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        resp_ready = 1'b0;
        chk("midrst_no_resp", 64'(seen), 64'd0);
        direct("after_rst", 3'd2, 32'h8000_0000, 32'h0000_0003, 4'd12, ref_mul(3'd2, 32'h8000_0000, 32'h0000_0003));

        // Randomized traffic; the model and compare process check every cycle.
        for (int c = 0; c < 4000; c++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_op     = 3'($urandom_range(0, 7));
            req_a      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            req_b      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            req_tag    = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 9) < 6);
            kill       = ($urandom_range(0, 199) == 0);
            tick();
        end
        req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b1;
        repeat (40) tick();
        chk("handshake_count", 64'(d_hs), 64'(m_hs));
        chk("handshakes_seen", 64'(d_hs > 20), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
